// File: rtl/running_enemy_pkg.sv
// Shared types, geometry constants and sprite ROM contents for the running-enemy sprite fetch.
package running_enemy_pkg;

    localparam int unsigned SPRITE_W    = 32;
    localparam int unsigned SPRITE_H    = 32;
    localparam int unsigned RUN_FRAMES  = 6;
    localparam int unsigned SHOOT_FRAME = 6;
    localparam int unsigned FRAME_DIV   = 4;
    localparam int unsigned SHOOT_HOLD  = 8;

    localparam int unsigned X_W       = $clog2(SPRITE_W);
    localparam int unsigned Y_W       = $clog2(SPRITE_H);
    localparam int unsigned FRAME_W   = 3;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ROM_DEPTH = (SHOOT_FRAME + 1) * SPRITE_W * SPRITE_H;
    localparam int unsigned ADDR_W    = $clog2(ROM_DEPTH);
    localparam int unsigned STEP_W    = $clog2(FRAME_DIV);
    localparam int unsigned HOLD_W    = $clog2(SHOOT_HOLD);

    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 3'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHOOT = 2'd2
    } anim_state_t;

    // Sprite art as a closed-form pattern of {frame, y, x}; index 0 marks transparent pixels.
    function automatic logic [IDX_W-1:0] rom_word(input logic [ADDR_W-1:0] addr);
        logic [7:0] s;
        s = 8'(addr[X_W-1:0])
          + 8'(addr[X_W +: Y_W]) * 8'd3
          + 8'(addr[ADDR_W-1 -: FRAME_W]) * 8'd5;
        return s[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/running_enemy_rom.sv
// Sprite ROM: 3-bit palette indices, ROM_DEPTH words, one-cycle registered read.
module running_enemy_rom
    import running_enemy_pkg::*;
(
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  data_o
);

    logic [IDX_W-1:0] data_q;

    always_ff @(posedge Clk) begin
        data_q <= rom_word(addr_i);
    end

    assign data_o = data_q;

endmodule

// File: rtl/running_enemy_sprite_fetch.sv
// Running-enemy pixel fetch (2-cycle pipeline) plus run/shoot animation FSM.
// Optional horizontal mirroring is enabled by defining RUNNING_ENEMY_MIRROR_EN.
module running_enemy_sprite_fetch
    import running_enemy_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_tick,
    input  logic               enemy_active,
    input  logic [COORD_W-1:0] enemy_x,
    input  logic [COORD_W-1:0] enemy_y,
    input  logic               facing_left,
    input  logic               shoot_req,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic [IDX_W-1:0]   pixel_index,
    output logic               pixel_hit,
    output logic [FRAME_W-1:0] anim_frame,
    output logic               shoot_fire
);

    // S0: sprite-relative coordinates; negative results wrap high and fail the bound test.
    logic [COORD_W:0]  dx_c;
    logic [COORD_W:0]  dy_c;
    logic              inside_c;
    logic [X_W-1:0]    dx_eff_c;
    logic [ADDR_W-1:0] rom_addr_c;

    assign dx_c     = {1'b0, DrawX} - {1'b0, enemy_x};
    assign dy_c     = {1'b0, DrawY} - {1'b0, enemy_y};
    assign inside_c = enemy_active
                    & (dx_c < (COORD_W+1)'(SPRITE_W))
                    & (dy_c < (COORD_W+1)'(SPRITE_H));

`ifdef RUNNING_ENEMY_MIRROR_EN
    assign dx_eff_c = facing_left ? (X_W'(SPRITE_W - 1) - dx_c[X_W-1:0]) : dx_c[X_W-1:0];
`else
    logic unused_facing_c;
    assign unused_facing_c = facing_left;
    assign dx_eff_c        = dx_c[X_W-1:0];
`endif

    logic [FRAME_W-1:0] anim_frame_q;

    assign rom_addr_c = {anim_frame_q, dy_c[Y_W-1:0], dx_eff_c};

    // S1: ROM read with the inside flag travelling alongside.
    logic [IDX_W-1:0] rom_data;
    logic             inside_q;

    running_enemy_rom u_rom (
        .Clk    (Clk),
        .addr_i (rom_addr_c),
        .data_o (rom_data)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            inside_q <= 1'b0;
        end else begin
            inside_q <= inside_c;
        end
    end

    // S2: mask transparent and out-of-sprite pixels.
    logic [IDX_W-1:0] pixel_index_q;
    logic             pixel_hit_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_index_q <= TRANSPARENT_IDX;
            pixel_hit_q   <= 1'b0;
        end else begin
            pixel_index_q <= inside_q ? rom_data : TRANSPARENT_IDX;
            pixel_hit_q   <= inside_q & (rom_data != TRANSPARENT_IDX);
        end
    end

    // Animation FSM: frame_tick-driven except for the pending-shot latch.
    anim_state_t        state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [FRAME_W-1:0] anim_frame_d;
    logic               pending_q, pending_d;
    logic               shoot_fire_q, shoot_fire_d;
    logic               shot_c;

    assign shot_c = pending_q | shoot_req;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            step_q       <= '0;
            hold_q       <= '0;
            anim_frame_q <= '0;
            pending_q    <= 1'b0;
            shoot_fire_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
            anim_frame_q <= anim_frame_d;
            pending_q    <= pending_d;
            shoot_fire_q <= shoot_fire_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        hold_d       = hold_q;
        anim_frame_d = anim_frame_q;
        shoot_fire_d = 1'b0;
        pending_d    = (state_q == RUN) ? shot_c : 1'b0;

        if (frame_tick) begin
            if (!enemy_active) begin
                state_d      = IDLE;
                step_d       = '0;
                hold_d       = '0;
                anim_frame_d = '0;
                pending_d    = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d      = RUN;
                        step_d       = '0;
                        anim_frame_d = '0;
                    end
                    RUN: begin
                        if (shot_c) begin
                            state_d      = SHOOT;
                            anim_frame_d = FRAME_W'(SHOOT_FRAME);
                            hold_d       = '0;
                            shoot_fire_d = 1'b1;
                            pending_d    = 1'b0;
                        end else if (step_q == STEP_W'(FRAME_DIV - 1)) begin
                            step_d       = '0;
                            anim_frame_d = (anim_frame_q == FRAME_W'(RUN_FRAMES - 1))
                                         ? '0 : anim_frame_q + FRAME_W'(1);
                        end else begin
                            step_d = step_q + STEP_W'(1);
                        end
                    end
                    SHOOT: begin
                        if (hold_q == HOLD_W'(SHOOT_HOLD - 1)) begin
                            state_d      = RUN;
                            step_d       = '0;
                            anim_frame_d = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    assign pixel_index = pixel_index_q;
    assign pixel_hit   = pixel_hit_q;
    assign anim_frame  = anim_frame_q;
    assign shoot_fire  = shoot_fire_q;

endmodule
